// File: rtl/sdram_device_model_if.sv
// SDR SDRAM command/data bus between a controller (master) and the device model (slave).
// Carries the decoded-pin view: command strobes, bank/address, byte masks, split DQ.
`timescale 1ns/1ps
interface sdram_device_model_if;
  logic        sd_cs_n;
  logic        sd_ras_n;
  logic        sd_cas_n;
  logic        sd_we_n;
  logic [1:0]  sd_ba;
  logic [12:0] sd_a;
  logic [1:0]  sd_dqm;
  logic [15:0] sd_dq_in;
  logic [15:0] sd_dq_out;
  logic        sd_dq_oe;

  modport master (
    output sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_ba, sd_a, sd_dqm, sd_dq_in,
    input  sd_dq_out, sd_dq_oe
  );

  modport slave (
    input  sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_ba, sd_a, sd_dqm, sd_dq_in,
    output sd_dq_out, sd_dq_oe
  );
endinterface

// File: rtl/sdram_device_model.sv
// SDR SDRAM device responder: per-bank row tracking, mode register, single-word RAM access.
// Latency: write on command edge; read data registered CL-1 edges after READ (CL 2 or 3).
// No backpressure: every command is accepted; SDRAM_ERRCHK_EN adds sticky error flags and tRCD counters.
`timescale 1ns/1ps
module sdram_device_model #(
  parameter int MEM_AW = 12,
  parameter int TRCD   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  sdram_device_model_if.slave  sd,
  output logic [12:0]          mode_reg,
  output logic [15:0]          refresh_cnt,
  output logic [4:0]           err
);

  typedef enum logic [3:0] {
    CMD_LOAD_MODE = 4'b0000,
    CMD_REFRESH   = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVE    = 4'b0011,
    CMD_WRITE     = 4'b0100,
    CMD_READ      = 4'b0101,
    CMD_IGNORE    = 4'b0110,
    CMD_NOP       = 4'b0111
  } cmd_e;

  typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_e;

  cmd_e        cmd;
  bank_e       bank_q [4];
  bank_e       bank_d [4];
  logic [12:0] row_q  [4];
  logic [12:0] row_d  [4];
  logic        mode_valid;
  logic        is_rd;
  logic        is_wr;
  logic        acc_ok;
  logic        cl3;
  logic [23:0] addr_full;
  logic [MEM_AW-1:0] mem_idx;
  logic        unused_addr;

  logic [15:0] mem [0:(1<<MEM_AW)-1];

  logic        p0_vld;
  logic        p0_cl3;
  logic [15:0] p0_dat;
  logic        p1_vld;
  logic [15:0] p1_dat;
  logic        dq_oe_q;
  logic [15:0] dq_out_q;

  assign cmd   = sd.sd_cs_n ? CMD_NOP : cmd_e'({1'b0, sd.sd_ras_n, sd.sd_cas_n, sd.sd_we_n});
  assign is_rd = (cmd == CMD_READ);
  assign is_wr = (cmd == CMD_WRITE);

  // Only the low MEM_AW bits of {ba,row,col} address the backing RAM.
  assign addr_full   = {sd.sd_ba, row_q[sd.sd_ba], sd.sd_a[8:0]};
  assign mem_idx     = addr_full[MEM_AW-1:0];
  assign unused_addr = &{1'b0, addr_full[23:MEM_AW]};

  // Unknown or not-yet-loaded CAS latency falls back to CL=2.
  assign cl3 = mode_valid && (mode_reg[6:4] == 3'd3);

  assign sd.sd_dq_out = dq_out_q;
  assign sd.sd_dq_oe  = dq_oe_q;

`ifdef SDRAM_ERRCHK_EN
  localparam int CW = (TRCD < 2) ? 1 : $clog2(TRCD + 1);

  logic          bank_open;
  logic          any_active;
  logic [4:0]    err_set;
  logic [4:0]    err_q;
  logic [CW-1:0] trcd_cnt [4];

  assign bank_open = (bank_q[sd.sd_ba] == BANK_ACTIVE);
  assign acc_ok    = bank_open;

  always_comb begin
    any_active = 1'b0;
    for (int i = 0; i < 4; i++) any_active = any_active | (bank_q[i] == BANK_ACTIVE);
  end

  always_comb begin
    err_set    = '0;
    err_set[0] = ((cmd == CMD_ACTIVE) && bank_open) ||
                 (((cmd == CMD_REFRESH) || (cmd == CMD_LOAD_MODE)) && any_active);
    err_set[1] = (is_rd || is_wr) && !bank_open;
    err_set[2] = (is_rd || is_wr) && bank_open && (trcd_cnt[sd.sd_ba] < CW'(TRCD));
    err_set[3] = (is_rd || is_wr) &&
                 (!mode_valid || ((mode_reg[6:4] != 3'd2) && (mode_reg[6:4] != 3'd3)));
    err_set[4] = is_wr && dq_oe_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
      for (int i = 0; i < 4; i++) trcd_cnt[i] <= CW'(TRCD);
    end else begin
      err_q <= err_q | err_set;
      for (int i = 0; i < 4; i++) begin
        if ((cmd == CMD_ACTIVE) && (sd.sd_ba == 2'(i)))
          trcd_cnt[i] <= '0;
        else if (trcd_cnt[i] < CW'(TRCD))
          trcd_cnt[i] <= trcd_cnt[i] + CW'(1);
      end
    end
  end

  assign err = err_q;
`else
  assign acc_ok = 1'b1;
  assign err    = '0;
`endif

  // Bank open/close decisions; rows only change on ACTIVE.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bank_d[i] = bank_q[i];
      row_d[i]  = row_q[i];
    end
    case (cmd)
      CMD_ACTIVE: begin
        bank_d[sd.sd_ba] = BANK_ACTIVE;
        row_d[sd.sd_ba]  = sd.sd_a;
      end
      CMD_READ, CMD_WRITE: begin
        if (acc_ok && sd.sd_a[10]) bank_d[sd.sd_ba] = BANK_IDLE;
      end
      CMD_PRECHARGE: begin
        if (sd.sd_a[10]) begin
          for (int i = 0; i < 4; i++) bank_d[i] = BANK_IDLE;
        end else begin
          bank_d[sd.sd_ba] = BANK_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        bank_q[i] <= BANK_IDLE;
        row_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        bank_q[i] <= bank_d[i];
        row_q[i]  <= row_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg    <= '0;
      mode_valid  <= 1'b0;
      refresh_cnt <= '0;
    end else begin
      if (cmd == CMD_LOAD_MODE) begin
        mode_reg   <= sd.sd_a;
        mode_valid <= 1'b1;
      end
      if ((cmd == CMD_REFRESH) && (refresh_cnt != 16'hFFFF))
        refresh_cnt <= refresh_cnt + 16'd1;
    end
  end

  // Backing RAM is never reset so its contents survive a re-init.
  always_ff @(posedge clk) begin
    if (!reset && is_wr && acc_ok) begin
      if (!sd.sd_dqm[0]) mem[mem_idx][7:0]  <= sd.sd_dq_in[7:0];
      if (!sd.sd_dqm[1]) mem[mem_idx][15:8] <= sd.sd_dq_in[15:8];
    end
  end

  always_ff @(posedge clk) begin
    p0_dat <= mem[mem_idx];
    p1_dat <= p0_dat;
  end

  // Read pipe: stage0 -> (stage1 for CL3) -> output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      p0_vld   <= 1'b0;
      p0_cl3   <= 1'b0;
      p1_vld   <= 1'b0;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      p0_vld <= is_rd && acc_ok;
      p0_cl3 <= cl3;
      p1_vld <= p0_vld && p0_cl3;
      if (p0_vld && !p0_cl3) begin
        dq_oe_q  <= 1'b1;
        dq_out_q <= p0_dat;
      end else if (p1_vld) begin
        dq_oe_q  <= 1'b1;
        dq_out_q <= p1_dat;
      end else begin
        dq_oe_q  <= 1'b0;
      end
    end
  end

endmodule
